// File: rtl/tdc_channel_arbiter_if.sv
// Valid/ready word stream, LANES lanes wide. The arbiter takes a CHANNEL-lane
// slave on the producer side and drives a one-lane master toward the encoder.
interface tdc_channel_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 1
);
    logic [LANES-1:0]                 valid;
    logic [LANES-1:0]                 ready;
    logic [LANES-1:0][DATA_WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/tdc_channel_arbiter.sv
// Round-robin burst scheduler: grants one enabled TDC channel at a time, emits a
// tagged header word and then up to BURST_LEN of that channel's words.
module tdc_channel_arbiter_lane #(
    parameter logic [2:0] ID = 3'd0
) (
    input  logic       valid,
    input  logic       on,
    input  logic       data_phase,
    input  logic       slot_free,
    input  logic [2:0] grant_ch,
    output logic       req,
    output logic       ready
);
    assign req   = valid & on;
    assign ready = data_phase && slot_free && (grant_ch == ID);
endmodule

module tdc_channel_arbiter #(
    parameter int         DATA_WIDTH = 32,
    parameter int         CHANNEL    = 8,
    parameter int         BURST_LEN  = 16,
    parameter logic [7:0] HDR_MAGIC  = 8'hC3
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                capture,
    input  logic [CHANNEL-1:0]  channel_on,
    tdc_channel_arbiter_if.slave  in_if,
    tdc_channel_arbiter_if.master out_if,
    output logic                busy,
    output logic [2:0]          grant_ch,
    output logic [15:0]         frame_seq
);
    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    state_t                state, state_nx;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [DATA_WIDTH-1:0] hdr;
    logic [2:0]            rr_ptr;
    logic [15:0]           burst_cnt;
    logic [15:0]           seq_q;
    logic [CHANNEL-1:0]    req;
    logic [CHANNEL-1:0]    lane_ready;
    logic                  slot_free, data_phase;
    logic                  g_valid, hs, load_hdr, last_word, grant_now;
    logic [2:0]            pick_ch, cand;
    logic                  pick_hit;

    assign slot_free = !out_valid_q || out_if.ready[0];
    assign g_valid   = in_if.valid[grant_ch];
    assign hs        = data_phase && g_valid && slot_free;
    assign load_hdr  = (state == HDR) && slot_free;
    assign last_word = (burst_cnt == 16'(BURST_LEN - 1));
    assign grant_now = (state == IDLE) && capture && (|req);

    for (genvar i = 0; i < CHANNEL; i++) begin : g_lane
        tdc_channel_arbiter_lane #(.ID(3'(i))) u_lane (
            .valid      (in_if.valid[i]),
            .on         (channel_on[i]),
            .data_phase (data_phase),
            .slot_free  (slot_free),
            .grant_ch   (grant_ch),
            .req        (req[i]),
            .ready      (lane_ready[i])
        );
    end
    assign in_if.ready = lane_ready;

    // Search starts one past the last served channel, so it ends up last in line.
    always_comb begin
        pick_hit = 1'b0;
        pick_ch  = '0;
        cand     = '0;
        for (int k = 1; k <= CHANNEL; k++) begin
            cand = rr_ptr + 3'(k);
            if (!pick_hit && req[cand]) begin
                pick_hit = 1'b1;
                pick_ch  = cand;
            end
        end
    end

    always_comb begin
        hdr                       = '0;
        hdr[DATA_WIDTH-1 -: 8]    = HDR_MAGIC;
        hdr[18:16]                = grant_ch;
        hdr[15:0]                 = seq_q;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (grant_now) state_nx = HDR;
            HDR:  if (slot_free) state_nx = DATA;
            // A missing word ends the burst even while the output is stalled.
            DATA: if (!g_valid || (hs && last_word)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        data_phase = (state == DATA);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            grant_ch    <= '0;
            rr_ptr      <= 3'd7;
            burst_cnt   <= '0;
            seq_q       <= '0;
        end else begin
            if (load_hdr) begin
                out_valid_q <= 1'b1;
                out_data_q  <= hdr;
                burst_cnt   <= '0;
                seq_q       <= seq_q + 16'd1;
            end else if (hs) begin
                out_valid_q <= 1'b1;
                out_data_q  <= in_if.data[grant_ch];
                burst_cnt   <= burst_cnt + 16'd1;
            end else if (out_if.ready[0]) begin
                out_valid_q <= 1'b0;
            end
            if (grant_now) grant_ch <= pick_ch;
            if (data_phase && (state_nx == IDLE)) rr_ptr <= grant_ch;
        end
    end

    assign out_if.valid = out_valid_q;
    assign out_if.data  = out_data_q;
    assign frame_seq    = seq_q;
endmodule

// File: tb/tb_tdc_channel_arbiter.sv
// Bench for tdc_channel_arbiter: gating table, directed burst sequences and
// randomized traffic checked by a frame-level stream model.
module tb_tdc_channel_arbiter;
    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        capture;
    logic [7:0]  channel_on;
    logic        busy;
    logic [2:0]  grant_ch;
    logic [15:0] frame_seq;

    tdc_channel_arbiter_if #(.DATA_WIDTH(32), .LANES(8)) in_if ();
    tdc_channel_arbiter_if #(.DATA_WIDTH(32), .LANES(1)) out_if ();

    tdc_channel_arbiter #(.DATA_WIDTH(32), .CHANNEL(8), .BURST_LEN(16), .HDR_MAGIC(8'hC3)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .capture    (capture),
        .channel_on (channel_on),
        .in_if      (in_if),
        .out_if     (out_if),
        .busy       (busy),
        .grant_ch   (grant_ch),
        .frame_seq  (frame_seq)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    // producer and stream model
    int          prod_cnt [8];
    int          prod_lim [8];
    int          out_cnt  [8];
    logic [7:0]  prod_en;
    logic [15:0] exp_seq;
    logic [2:0]  cur_ch;
    bit          in_frame;
    bit          prev_stall;
    logic [31:0] prev_data;
    logic [7:0]  ir_seen;
    logic [31:0] hdr_q[$];
    int          flen[$];
    int          hdr_tick[$];
    logic [31:0] stream_q[$];
    logic [31:0] ref_stream[$];
    int          tick_n;
    int          rdy_mode;
    int          stretch;
    bit          toggle;

    typedef struct {
        logic       cap;
        logic [7:0] on;
        logic [7:0] vld;
        logic       has;
        logic [2:0] ch;
    } vec_t;
    vec_t vecs[9];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word(int ch, int n);
        return 32'(ch << 20) | 32'(n + 1);
    endfunction

    task automatic take(logic [31:0] w);
        stream_q.push_back(w);
        if (w[31:24] == 8'hC3) begin
            chk("hdr_seq", 64'(w[15:0]), 64'(exp_seq));
            chk("hdr_pad", 64'(w[23:19]), 64'd0);
            exp_seq  = exp_seq + 16'd1;
            cur_ch   = w[18:16];
            in_frame = 1'b1;
            hdr_q.push_back(w);
            flen.push_back(0);
            hdr_tick.push_back(tick_n);
        end else begin
            chk("data_in_frame", 64'(in_frame), 64'd1);
            if (in_frame) begin
                chk("burst_bound", 64'(flen[flen.size()-1] < 16), 64'd1);
                chk("data_word", 64'(w), 64'(word(int'(cur_ch), out_cnt[cur_ch])));
                out_cnt[cur_ch]++;
                flen[flen.size()-1]++;
            end
        end
    endtask

    task automatic tick();
        logic r;
        @(negedge sys_clk);
        case (rdy_mode)
            0: r = 1'b1;
            1: begin
                if (stretch > 0) begin
                    r = 1'b0;
                    stretch--;
                end else begin
                    r = toggle;
                    toggle = !toggle;
                    if ($urandom_range(0, 15) == 0) stretch = 10;
                end
            end
            default: r = ($urandom_range(0, 3) != 0);
        endcase
        out_if.ready[0] = r;
        for (int i = 0; i < 8; i++) begin
            in_if.valid[i] = prod_en[i] && (prod_cnt[i] < prod_lim[i]);
            in_if.data[i]  = word(i, prod_cnt[i]);
        end
        #1;
        tick_n++;
        if (prev_stall) begin
            chk("stall_valid", 64'(out_if.valid[0]), 64'd1);
            chk("stall_data", 64'(out_if.data[0]), 64'(prev_data));
        end
        if (out_if.valid[0] && out_if.ready[0]) take(out_if.data[0]);
        ir_seen |= in_if.ready;
        if (in_if.ready != 8'd0)
            chk("in_ready_grant", 64'(in_if.ready), 64'(in_frame ? (8'd1 << cur_ch) : 8'd0));
        for (int i = 0; i < 8; i++)
            if (in_if.valid[i] && in_if.ready[i]) prod_cnt[i]++;
        prev_stall = out_if.valid[0] && !out_if.ready[0];
        prev_data  = out_if.data[0];
    endtask

    task automatic reset_all();
        sys_rst    = 1'b1;
        capture    = 1'b0;
        channel_on = 8'h00;
        rdy_mode   = 0;
        prod_en    = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            prod_cnt[i] = 0;
            prod_lim[i] = 0;
            out_cnt[i]  = 0;
        end
        in_if.valid = '0;
        in_if.data  = '0;
        out_if.ready = 1'b1;
        hdr_q.delete(); flen.delete(); hdr_tick.delete(); stream_q.delete();
        exp_seq = 16'd0; cur_ch = 3'd0; in_frame = 1'b0; prev_stall = 1'b0;
        prev_data = '0; ir_seen = '0; stretch = 0; toggle = 1'b1;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    function automatic bit drained();
        bit d;
        d = !busy && !out_if.valid[0];
        for (int i = 0; i < 8; i++)
            if (channel_on[i] && prod_cnt[i] < prod_lim[i]) d = 1'b0;
        return d;
    endfunction

    initial begin
        int n;
        tick_n = 0;
        reset_all();

        // reset state
        chk("rst_out_valid", 64'(out_if.valid[0]), 64'd0);
        chk("rst_out_data", 64'(out_if.data[0]), 64'd0);
        chk("rst_in_ready", 64'(in_if.ready), 64'd0);
        chk("rst_grant_ch", 64'(grant_ch), 64'd0);
        chk("rst_frame_seq", 64'(frame_seq), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);

        // gating / first-grant table (rr pointer starts at 7 -> search begins at ch0)
        vecs[0] = '{1'b0, 8'hFF, 8'hFF, 1'b0, 3'd0};
        vecs[1] = '{1'b1, 8'h00, 8'hFF, 1'b0, 3'd0};
        vecs[2] = '{1'b1, 8'hFE, 8'h01, 1'b0, 3'd0};
        vecs[3] = '{1'b1, 8'hFF, 8'h00, 1'b0, 3'd0};
        vecs[4] = '{1'b1, 8'h04, 8'h04, 1'b1, 3'd2};
        vecs[5] = '{1'b1, 8'hFF, 8'hFF, 1'b1, 3'd0};
        vecs[6] = '{1'b1, 8'hF0, 8'h3C, 1'b1, 3'd4};
        vecs[7] = '{1'b1, 8'h81, 8'h80, 1'b1, 3'd7};
        vecs[8] = '{1'b1, 8'hFF, 8'hC0, 1'b1, 3'd6};
        for (int v = 0; v < 9; v++) begin
            reset_all();
            capture    = vecs[v].cap;
            channel_on = vecs[v].on;
            prod_en    = vecs[v].vld;
            for (int i = 0; i < 8; i++) prod_lim[i] = 1000;
            repeat (12) tick();
            chk($sformatf("gate_has_hdr[%0d]", v), 64'(hdr_q.size() > 0), 64'(vecs[v].has));
            if (vecs[v].has && hdr_q.size() > 0)
                chk($sformatf("gate_first_ch[%0d]", v), 64'(hdr_q[0][18:16]), 64'(vecs[v].ch));
        end

        // single channel, 20 words -> 16 + 4
        reset_all();
        capture = 1'b1; channel_on = 8'h04; prod_lim[2] = 20;
        n = 0;
        while (n < 300 && !(out_cnt[2] == 20 && !busy)) begin tick(); n++; end
        chk("single_done", 64'(n < 300), 64'd1);
        chk("single_hdrs", 64'(hdr_q.size()), 64'd2);
        if (hdr_q.size() == 2) begin
            chk("single_hdr0", 64'(hdr_q[0]), 64'hC3020000);
            chk("single_hdr1", 64'(hdr_q[1]), 64'hC3020001);
            chk("single_len0", 64'(flen[0]), 64'd16);
            chk("single_len1", 64'(flen[1]), 64'd4);
            chk("single_hdr_gap", 64'(hdr_tick[1] - hdr_tick[0]), 64'd18);
        end
        chk("single_ready_bits", 64'(ir_seen), 64'h04);

        // fairness: all on, all valid
        reset_all();
        capture = 1'b1; channel_on = 8'hFF;
        for (int i = 0; i < 8; i++) prod_lim[i] = 1000;
        n = 0;
        while (n < 2000 && hdr_q.size() < 10) begin tick(); n++; end
        chk("fair_done", 64'(n < 2000), 64'd1);
        if (hdr_q.size() >= 10) begin
            for (int k = 0; k < 9; k++) begin
                chk($sformatf("fair_ch[%0d]", k), 64'(hdr_q[k][18:16]), 64'(k % 8));
                chk($sformatf("fair_len[%0d]", k), 64'(flen[k]), 64'd16);
            end
        end
        ref_stream = stream_q[0:152];

        // same traffic under backpressure must give the same word sequence
        reset_all();
        capture = 1'b1; channel_on = 8'hFF; rdy_mode = 1;
        for (int i = 0; i < 8; i++) prod_lim[i] = 1000;
        n = 0;
        while (n < 4000 && stream_q.size() < 153) begin tick(); n++; end
        chk("bp_done", 64'(n < 4000), 64'd1);
        begin
            int bad = 0;
            int first = -1;
            for (int k = 0; k < 153 && k < stream_q.size(); k++)
                if (stream_q[k] !== ref_stream[k]) begin
                    bad++;
                    if (first < 0) first = k;
                end
            chk("bp_stream_diffs", 64'(bad), 64'd0);
            if (first >= 0) chk("bp_first_diff", 64'(stream_q[first]), 64'(ref_stream[first]));
        end

        // short burst on ch5
        reset_all();
        capture = 1'b1; channel_on = 8'h20; prod_lim[5] = 3;
        repeat (30) tick();
        chk("short_hdrs", 64'(hdr_q.size()), 64'd1);
        if (flen.size() > 0) chk("short_len", 64'(flen[0]), 64'd3);
        chk("short_idle", 64'(busy), 64'd0);
        chk("short_words", 64'(out_cnt[5]), 64'd3);

        // drop capture and channel_on mid-burst: burst still runs to 16
        reset_all();
        capture = 1'b1; channel_on = 8'h08; prod_lim[3] = 1000;
        repeat (80) begin
            tick();
            if (flen.size() > 0 && flen[0] == 5 && capture) begin
                capture = 1'b0;
                channel_on = 8'h00;
            end
        end
        chk("middis_hdrs", 64'(hdr_q.size()), 64'd1);
        if (flen.size() > 0) chk("middis_len", 64'(flen[0]), 64'd16);
        chk("middis_idle", 64'(busy), 64'd0);

        // sequence wrap
        reset_all();
        @(negedge sys_clk);
        force dut.seq_q = 16'hFFFF;
        @(negedge sys_clk);
        release dut.seq_q;
        exp_seq = 16'hFFFF;
        #1;
        chk("wrap_preload", 64'(frame_seq), 64'hFFFF);
        capture = 1'b1; channel_on = 8'h02; prod_lim[1] = 20;
        n = 0;
        while (n < 300 && !(out_cnt[1] == 20 && !busy)) begin tick(); n++; end
        chk("wrap_done", 64'(n < 300), 64'd1);
        if (hdr_q.size() == 2) begin
            chk("wrap_hdr0", 64'(hdr_q[0]), 64'hC301FFFF);
            chk("wrap_hdr1", 64'(hdr_q[1]), 64'hC3010000);
        end else chk("wrap_hdrs", 64'(hdr_q.size()), 64'd2);
        chk("wrap_seq_after", 64'(frame_seq), 64'd1);

        // async reset mid-DATA
        reset_all();
        capture = 1'b1; channel_on = 8'h08; prod_lim[3] = 1000;
        n = 0;
        while (n < 200 && !(out_if.valid[0] && in_frame && flen.size() > 0 && flen[0] >= 3)) begin
            tick(); n++;
        end
        chk("arst_reach", 64'(n < 200), 64'd1);
        #2 sys_rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_if.valid[0]), 64'd0);
        chk("arst_in_ready", 64'(in_if.ready), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        reset_all();
        capture = 1'b1; channel_on = 8'hFF;
        for (int i = 0; i < 8; i++) prod_lim[i] = 100;
        n = 0;
        while (n < 50 && hdr_q.size() == 0) begin tick(); n++; end
        chk("arst_hdr_seen", 64'(hdr_q.size() > 0), 64'd1);
        if (hdr_q.size() > 0) chk("arst_first_hdr", 64'(hdr_q[0]), 64'hC3000000);

        // random traffic, random valid gaps and backpressure
        for (int it = 0; it < 4; it++) begin
            reset_all();
            capture = 1'b1;
            channel_on = 8'($urandom_range(1, 255));
            rdy_mode = 2;
            for (int i = 0; i < 8; i++) prod_lim[i] = $urandom_range(0, 40);
            repeat (500) begin
                prod_en = 8'($urandom);
                tick();
            end
            prod_en = 8'hFF;
            n = 0;
            while (n < 3000 && !drained()) begin tick(); n++; end
            chk($sformatf("rnd_drain[%0d]", it), 64'(n < 3000), 64'd1);
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("rnd_out_cnt[%0d][%0d]", it, i), 64'(out_cnt[i]), 64'(prod_cnt[i]));
                chk($sformatf("rnd_in_cnt[%0d][%0d]", it, i), 64'(prod_cnt[i]),
                    64'(channel_on[i] ? prod_lim[i] : 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
